// File: rtl/local_ni.sv
// local_ni: network interface on a router's local port.
// Injection side drives the router under credit flow control; ejection side
// buffers router flits in a first-word-fall-through FIFO and returns one
// credit pulse per flit consumed by the core.
module local_ni #(
  parameter int unsigned FLIT_W     = 32,
  parameter int unsigned RX_DEPTH   = 4,
  parameter int unsigned TX_CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] core_tx_data_i,
  input  logic              core_tx_valid_i,
  output logic              core_tx_ready_o,
  output logic [FLIT_W-1:0] local_o,
  output logic              local_valid_o,
  input  logic              tx_credit_i,
  input  logic [FLIT_W-1:0] local_i,
  input  logic              local_valid_i,
  output logic              l_incr_o,
  output logic [FLIT_W-1:0] core_rx_data_o,
  output logic              core_rx_valid_o,
  input  logic              core_rx_ready_i,
  output logic              credit_err_o,
  output logic              ovf_err_o
);

  localparam int unsigned CNT_W = $clog2(TX_CREDITS + 1);
  localparam int unsigned OCC_W = $clog2(RX_DEPTH + 1);
  localparam int unsigned PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  logic [CNT_W-1:0]  cnt;
  logic              fire;

  logic [FLIT_W-1:0] mem [RX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              full;
  logic              pop;
  logic              push_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RX_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready depends only on the registered credit count.
  assign core_tx_ready_o = (cnt != '0);
  assign fire            = core_tx_valid_i & core_tx_ready_o;

  // Credit counter: spend one per fire, regain one per return pulse; saturate and flag a surplus credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= CNT_W'(TX_CREDITS);
      credit_err_o <= 1'b0;
    end else begin
      case ({fire, tx_credit_i})
        2'b10:   cnt <= cnt - CNT_W'(1);
        2'b01: begin
          if (cnt == CNT_W'(TX_CREDITS)) credit_err_o <= 1'b1;
          else                           cnt          <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered injection path: one cycle from core to router.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      local_o       <= '0;
      local_valid_o <= 1'b0;
    end else begin
      local_valid_o <= fire;
      if (fire) local_o <= core_tx_data_i;
    end
  end

  assign full            = (occ == OCC_W'(RX_DEPTH));
  assign core_rx_valid_o = (occ != '0);
  assign core_rx_data_o  = mem[rd_ptr];
  assign pop             = core_rx_valid_o & core_rx_ready_i;
  assign push_ok         = local_valid_i & (~full | pop);

  // Ejection FIFO storage, pointers and occupancy; a push into a full FIFO is dropped unless a pop frees the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RX_DEPTH); i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      ovf_err_o <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= local_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: ;
      endcase
      if (local_valid_i & full & ~pop) ovf_err_o <= 1'b1;
    end
  end

  // One credit pulse back to the router per flit the core consumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) l_incr_o <= 1'b0;
    else     l_incr_o <= pop;
  end

endmodule

// File: tb/tb_local_ni.sv
// Self-checking bench for local_ni: directed stimulus plus a scoreboard monitor
// that tracks credits, FIFO occupancy and sticky flags on its own.
module tb_local_ni;

  localparam int unsigned FLIT_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CRED   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [FLIT_W-1:0] tx_d;
  logic              tx_v;
  logic              tx_rdy;
  logic [FLIT_W-1:0] local_o;
  logic              local_valid_o;
  logic              cred;
  logic [FLIT_W-1:0] rx_d;
  logic              rx_v;
  logic              l_incr;
  logic [FLIT_W-1:0] core_rx_data;
  logic              core_rx_valid;
  logic              rx_rdy;
  logic              credit_err;
  logic              ovf_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [FLIT_W-1:0] tx_q [$];
  logic [FLIT_W-1:0] rx_q [$];
  int  mcnt;
  int  mrx;
  bit  mcred_err, movf, prev_fire, prev_pop, m_fire, m_pop, m_acc;

  local_ni #(.FLIT_W(FLIT_W), .RX_DEPTH(DEPTH), .TX_CREDITS(CRED)) dut (
    .clk             (clk),
    .rst             (rst),
    .core_tx_data_i  (tx_d),
    .core_tx_valid_i (tx_v),
    .core_tx_ready_o (tx_rdy),
    .local_o         (local_o),
    .local_valid_o   (local_valid_o),
    .tx_credit_i     (cred),
    .local_i         (rx_d),
    .local_valid_i   (rx_v),
    .l_incr_o        (l_incr),
    .core_rx_data_o  (core_rx_data),
    .core_rx_valid_o (core_rx_valid),
    .core_rx_ready_i (rx_rdy),
    .credit_err_o    (credit_err),
    .ovf_err_o       (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor/scoreboard: compares outputs each cycle, then advances the reference model.
  always @(negedge clk) begin
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      mcnt = CRED; mrx = 0;
      mcred_err = 0; movf = 0; prev_fire = 0; prev_pop = 0;
    end else begin
      chk("credit_err", credit_err, mcred_err);
      chk("ovf_err", ovf_err, movf);
      chk("tx_ready", tx_rdy, mcnt != 0);
      chk("local_valid", local_valid_o, prev_fire);
      if (local_valid_o) begin
        if (tx_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL local_data: got %0h expected none", local_o);
        end else chk("local_data", local_o, tx_q.pop_front());
      end
      chk("rx_valid", core_rx_valid, mrx != 0);
      chk("l_incr", l_incr, prev_pop);
      m_pop = (mrx != 0) && rx_rdy;
      if (m_pop) begin
        if (rx_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rx_data: got %0h expected none", core_rx_data);
        end else chk("rx_data", core_rx_data, rx_q.pop_front());
      end
      // model update for the coming edge
      m_fire = tx_v && (mcnt != 0);
      if (m_fire) tx_q.push_back(tx_d);
      if (m_fire && !cred) mcnt--;
      else if (!m_fire && cred) begin
        if (mcnt == CRED) mcred_err = 1;
        else mcnt++;
      end
      m_acc = rx_v && ((mrx < DEPTH) || m_pop);
      if (rx_v && !m_acc) movf = 1;
      if (m_acc) rx_q.push_back(rx_d);
      mrx = mrx + int'(m_acc) - int'(m_pop);
      prev_fire = m_fire;
      prev_pop  = m_pop;
    end
  end

  initial begin
    rst = 1'b1; tx_d = '0; tx_v = 0; cred = 0; rx_d = '0; rx_v = 0; rx_rdy = 0;
    step(); step();
    rst = 1'b0;
    step();
    // reset / idle state
    chk("rst_ready", tx_rdy, 1);
    chk("rst_rx_valid", core_rx_valid, 0);
    chk("rst_rx_data", core_rx_data, 0);
    chk("rst_l_incr", l_incr, 0);
    chk("rst_local_valid", local_valid_o, 0);
    chk("rst_local_o", local_o, 0);
    chk("rst_credit_err", credit_err, 0);
    chk("rst_ovf_err", ovf_err, 0);

    // five back-to-back flits with four credits; fifth held until a credit returns
    for (int i = 0; i < 5; i++) begin
      tx_v = 1; tx_d = 32'hA0 + FLIT_W'(i);
      step();
    end
    chk("credits_exhausted", tx_rdy, 0);
    step();
    cred = 1;                 // same-cycle credit must not raise ready
    chk("ready_same_cycle_credit", tx_rdy, 0);
    step();
    cred = 0;
    chk("ready_after_credit", tx_rdy, 1);
    step();                   // A4 fires at this edge
    tx_v = 0;
    chk("a4_out_valid", local_valid_o, 1);
    chk("a4_out_data", local_o, 32'hA4);
    for (int i = 0; i < 4; i++) begin
      cred = 1; step();
    end
    cred = 0; step();

    // continuous injection with a credit every cycle
    for (int i = 0; i < 10; i++) begin
      tx_v = 1; cred = 1; tx_d = 32'hB0 + FLIT_W'(i);
      step();
      chk("steady_ready", tx_rdy, 1);
    end
    tx_v = 0; cred = 0; step(); step();
    chk("no_credit_err", credit_err, 0);
    // surplus credit at full count
    cred = 1; step(); cred = 0;
    chk("credit_err_set", credit_err, 1);
    chk("credit_err_ready", tx_rdy, 1);
    step();

    // fill the ejection FIFO with the core stalled
    rx_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      rx_v = 1; rx_d = 32'h10 + FLIT_W'(i);
      step();
    end
    rx_v = 0;
    chk("full_valid", core_rx_valid, 1);
    chk("full_head", core_rx_data, 32'h10);
    chk("full_l_incr", l_incr, 0);
    // push into full FIFO without a pop: dropped
    rx_v = 1; rx_d = 32'h55; step();
    rx_v = 0;
    chk("ovf_set", ovf_err, 1);
    chk("ovf_head", core_rx_data, 32'h10);
    // push into full FIFO with a same-cycle pop: accepted as tail
    rx_v = 1; rx_d = 32'h55; rx_rdy = 1; step();
    rx_v = 0;
    chk("pop_head_next", core_rx_data, 32'h11);
    for (int i = 0; i < 4; i++) step();
    rx_rdy = 0;
    chk("drained", core_rx_valid, 0);
    chk("ovf_sticky", ovf_err, 1);
    step();

    // pointer wrap: 9 flits streamed through
    rx_rdy = 1;
    for (int i = 0; i < 9; i++) begin
      rx_v = 1; rx_d = 32'hC0 + FLIT_W'(i);
      step();
    end
    rx_v = 0;
    step(); step();
    rx_rdy = 0;
    chk("wrap_empty", core_rx_valid, 0);

    // build 2 queued rx flits and cnt=1, then reset asynchronously mid-cycle
    for (int i = 0; i < 3; i++) begin
      tx_v = 1; tx_d = 32'hE0 + FLIT_W'(i);
      rx_v = (i < 2); rx_d = 32'hD0 + FLIT_W'(i);
      step();
    end
    tx_v = 0; rx_v = 0;
    chk("pre_rst_ready", tx_rdy, 1);
    chk("pre_rst_rx_valid", core_rx_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rx_valid", core_rx_valid, 0);
    chk("async_rst_ready", tx_rdy, 1);
    chk("async_rst_local_valid", local_valid_o, 0);
    chk("async_rst_credit_err", credit_err, 0);
    chk("async_rst_ovf", ovf_err, 0);
    chk("async_rst_rx_data", core_rx_data, 0);
    step();
    rst = 1'b0;
    // full credit count restored: four fires then ready drops
    for (int i = 0; i < 4; i++) begin
      tx_v = 1; tx_d = 32'hF0 + FLIT_W'(i);
      step();
    end
    tx_v = 0;
    chk("post_rst_credits", tx_rdy, 0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/local_ni.md
Name: local_ni

Overview:
Network interface sitting on the router's local port, the other end of the router's local link.
- Injection: takes flits from the attached core and drives the router's local input under credit-based flow control, consuming one credit per flit and regaining credits on the router's return pulse.
- Ejection: buffers flits arriving from the router's local output in a FIFO and, each time the core consumes one, returns a one-cycle credit pulse that feeds the router's l_incr_i.

Parameters:
FLIT_W, 32, flit width in bits (header/payload opaque to this block).
RX_DEPTH, 4, ejection FIFO depth; must equal the router's initial local output credit count.
TX_CREDITS, 4, initial injection credits; must equal the router's local input buffer depth.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
core_tx_data_i  in  FLIT_W  flit from core
core_tx_valid_i  in  1  core flit valid
core_tx_ready_o  out  1  injection accepts flit this cycle
local_o  out  FLIT_W  flit to router local_i
local_valid_o  out  1  local_o carries a flit this cycle
tx_credit_i  in  1  one-cycle credit return pulse from router (local input buffer pop)
local_i  in  FLIT_W  flit from router local_o
local_valid_i  in  1  local_i carries a flit this cycle
l_incr_o  out  1  one-cycle credit pulse to router l_incr_i
core_rx_data_o  out  FLIT_W  head of ejection FIFO
core_rx_valid_o  out  1  ejection FIFO non-empty
core_rx_ready_i  in  1  core consumes head flit
credit_err_o  out  1  sticky: credit returned while counter at TX_CREDITS
ovf_err_o  out  1  sticky: flit arrived into full FIFO with no same-cycle pop

Behaviour:
- Reset (async, any time, including mid-transfer):
  - Outputs: local_o=0, local_valid_o=0, l_incr_o=0, core_rx_valid_o=0, core_rx_data_o=0, credit_err_o=0, ovf_err_o=0.
  - State: credit counter=TX_CREDITS, FIFO empty, in-flight flits discarded.
- TX credit counter:
  - Width $clog2(TX_CREDITS+1).
  - core_tx_ready_o = (cnt != 0), combinational from the registered count only; a same-cycle tx_credit_i does not raise ready.
  - fire = core_tx_valid_i & core_tx_ready_o.
  - cnt_next = cnt - fire + tx_credit_i. A simultaneous fire and credit leaves cnt unchanged.
  - If tx_credit_i arrives with cnt==TX_CREDITS and no fire: cnt holds (saturates) and credit_err_o sets.
- TX datapath:
  - Registered. On fire, local_o <= core_tx_data_i and local_valid_o <= 1 in the next cycle; otherwise local_valid_o <= 0 and local_o holds.
  - Latency core to router: 1 cycle. Back-to-back fires produce back-to-back valid cycles.
- RX FIFO:
  - Circular buffer, RX_DEPTH entries, read/write pointers wrap at RX_DEPTH, occupancy counter width $clog2(RX_DEPTH+1).
  - First-word fall-through: core_rx_data_o = mem[rd_ptr] and core_rx_valid_o = (count != 0).
  - push = local_valid_i. pop = core_rx_valid_o & core_rx_ready_i.
  - Push when full with no pop: flit dropped, ovf_err_o sets, state unchanged.
  - Push when full with a same-cycle pop: accepted, count stays RX_DEPTH.
  - Push when empty: data visible on core_rx_data_o the next cycle; no combinational bypass.
- Credit return: l_incr_o <= pop (registered), so exactly one pulse per consumed flit, one cycle after the pop. Consecutive pops give consecutive pulses.
- Error flags: sticky until rst; they do not block operation.

Test Plan:
- Reset then idle: cnt=4, core_tx_ready_o=1, core_rx_valid_o=0, l_incr_o=0, both error flags 0.
- Inject 5 flits 0xA0..0xA4 back-to-back, no credits: 0xA0..0xA3 appear on local_o in cycles 1..4 with local_valid_o=1; ready drops after the 4th fire; 0xA4 held. One tx_credit_i pulse -> ready=1 next cycle, 0xA4 sent the following cycle.
- Inject with tx_credit_i asserted every cycle: ready stays 1 and cnt stays 4 through 10 continuous flits.
- Router delivers 4 flits 0x10..0x13 with core_rx_ready_i=0: count=4, head=0x10, l_incr_o=0. Raise ready for 4 cycles: data 0x10..0x13 in order, l_incr_o pulses on 4 consecutive cycles, each lagging its pop by 1.
- FIFO full + 5th flit 0x55 without pop -> dropped, ovf_err_o=1. Repeat with a same-cycle pop -> 0x55 accepted as tail, ovf_err_o unchanged.
- Pointer wrap and reset: push/pop 9 flits through a depth-4 FIFO, order preserved. Assert rst mid-stream with 2 flits queued and cnt=1 -> core_rx_valid_o=0 and cnt=4 immediately, asynchronously.
